lsu_ctrl: RTL

//  Load/store unit between the core execute stage and the word-only dmem. It

---
 rtl/lsu_ctrl.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/lsu_ctrl.sv
// lsu_ctrl -- load/store unit between the execute stage and a word-only dmem.
//
// Byte, halfword and word accesses are turned into aligned dmem word accesses.
// Sub-word stores do a read-modify-write. Load results are sign- or
// zero-extended. dmem read data is registered, so reads take an extra cycle.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned H/HU (addr[0]=1) or W (addr[1:0]!=0) requests
//               complete one cycle after acceptance with o_err=1, o_rdata=0
//               and no dmem access.
//   undefined : o_err stays 0; the low address bits below the access size are
//               ignored and the access proceeds normally.
//
// Ports
//   i_clk, i_reset   clock; synchronous active-high reset
//   i_req            request, sampled while o_ready=1
//   i_we             1=store, 0=load
//   i_funct3         000 B, 001 H, 010 W, 100 BU, 101 HU; others act as W
//   i_addr           byte address
//   i_wdata          right-aligned store data
//   o_ready          idle, a new request can be accepted
//   o_done           one-cycle completion pulse
//   o_rdata          extended load result, held after o_done
//   o_err            misaligned flag, qualified by o_done
//   o_mem_addr       dmem word address (bits [1:0] are 0)
//   o_mem_wdata      dmem write data
//   o_mem_wren       dmem write enable
//   i_mem_rdata      dmem registered read data
module lsu_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [2:0]        i_funct3,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic              o_ready,
  output logic              o_done,
  output logic [31:0]       o_rdata,
  output logic              o_err,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_mem_wren,
  input  logic [31:0]       i_mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_CAPT  = 3'd2,
    S_MERGE = 3'd3,  // merge is folded into CAPT; encoding kept for completeness
    S_WR    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  // Access size from direction and funct3. Stores only know B/H; every other
  // code, and every unlisted load code, is a word access.
  function automatic size_t f_size(input logic we, input logic [2:0] f3);
    size_t s;
    s = SZ_W;
    if (we) begin
      if (f3 == 3'b000)      s = SZ_B;
      else if (f3 == 3'b001) s = SZ_H;
    end else begin
      if (f3 == 3'b000 || f3 == 3'b100)      s = SZ_B;
      else if (f3 == 3'b001 || f3 == 3'b101) s = SZ_H;
    end
    return s;
  endfunction

  state_t             state_q, state_d;
  logic               we_q, we_d;
  logic [2:0]         f3_q, f3_d;
  logic [1:0]         lsb_q, lsb_d;
  logic [15:0]        wdata_q, wdata_d;   // only sub-word stores need it later
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  size_t              req_size, cur_size;
  logic               accept, misalign;
  logic [31:0]        sh_b, sh_h, load_val, merged;

  assign req_size = f_size(i_we, i_funct3);
  assign cur_size = f_size(we_q, f3_q);
  assign accept   = i_req & (state_q == S_IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((req_size == SZ_H) & i_addr[0]) |
                    ((req_size == SZ_W) & (i_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Lane extraction from the word just read.
  assign sh_b = i_mem_rdata >> {lsb_q, 3'b000};
  assign sh_h = i_mem_rdata >> {lsb_q[1], 4'b0000};

  always_comb begin
    load_val = i_mem_rdata;
    case (cur_size)
      SZ_B:    load_val = {{24{~f3_q[2] & sh_b[7]}}, sh_b[7:0]};
      SZ_H:    load_val = {{16{~f3_q[2] & sh_h[15]}}, sh_h[15:0]};
      default: load_val = i_mem_rdata;
    endcase
  end

  // Store merge: only the addressed lanes take new data.
  always_comb begin
    merged = i_mem_rdata;
    if (cur_size == SZ_B)
      merged[{lsb_q, 3'b000} +: 8] = wdata_q[7:0];
    else
      merged[{lsb_q[1], 4'b0000} +: 16] = wdata_q;
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    f3_d        = f3_q;
    lsb_d       = lsb_q;
    wdata_d     = wdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          we_d    = i_we;
          f3_d    = i_funct3;
          lsb_d   = i_addr[1:0];
          wdata_d = i_wdata[15:0];
          if (misalign) begin
            // Trap completes immediately; dmem outputs are left untouched.
            done_d  = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            mem_addr_d = {i_addr[ADDR_W-1:2], 2'b00};
            if (i_we && req_size == SZ_W) begin
              mem_wdata_d = i_wdata;
              state_d     = S_WR;
            end else begin
              state_d = S_RD;
            end
          end
        end
      end
      S_RD:   state_d = S_CAPT;
      S_CAPT: begin
        if (!we_q) begin
          rdata_d = load_val;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          mem_wdata_d = merged;
          state_d     = S_WR;
        end
      end
      S_WR: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      f3_q        <= 3'b000;
      lsb_q       <= 2'b00;
      wdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      lsb_q       <= lsb_d;
      wdata_q     <= wdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign o_ready     = (state_q == S_IDLE);
  assign o_done      = done_q;
  assign o_rdata     = rdata_q;
  assign o_err       = err_q;   // constant 0 unless the trap is compiled in
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  // Gated by reset so a reset landing on the write cycle cannot corrupt dmem.
  assign o_mem_wren  = (state_q == S_WR) & ~i_reset;

endmodule
